// File: rtl/fft_pkg.sv
// Shared types and defaults for the radix-2 DIT FFT stage sequencer.
// Holds the FSM state enum, default geometry and the bit-reversal helper.
package fft_pkg;

  localparam int DEF_N          = 1024;
  localparam int DEF_ADDR_SIZE  = 10;
  localparam int DEF_RD_LAT     = 1;
  localparam int DEF_BF_LATENCY = 4;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    SWAP,
    FIN
  } fft_state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) r[i] = v[w-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_delay.sv
// Valid plus address-pair shift register that turns issued read pairs
// into write strobes and write addresses DEPTH cycles later.
module fft_addr_delay
  import fft_pkg::*;
#(
  parameter int W     = DEF_ADDR_SIZE,
  parameter int DEPTH = DEF_RD_LAT + DEF_BF_LATENCY
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         src_valid,
  input  logic [W-1:0] src_a0,
  input  logic [W-1:0] src_a1,
  output logic         wr_en,
  output logic [W-1:0] wr_a0,
  output logic [W-1:0] wr_a1
);

  logic [DEPTH-1:0] vld;
  logic [W-1:0]     a0 [DEPTH];
  logic [W-1:0]     a1 [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a0[i] <= '0;
        a1[i] <= '0;
      end
    end else begin
      vld[0] <= src_valid;
      a0[0]  <= src_a0;
      a1[0]  <= src_a1;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        a0[i]  <= a0[i-1];
        a1[i]  <= a1[i-1];
      end
    end
  end

  // Addresses read as zero whenever no write is being strobed.
  assign wr_en = vld[DEPTH-1];
  assign wr_a0 = vld[DEPTH-1] ? a0[DEPTH-1] : '0;
  assign wr_a1 = vld[DEPTH-1] ? a1[DEPTH-1] : '0;

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer over a ping-pong ram_block.
// Define FFT_CTRL_BITREV_EN to bit-reverse stage-0 read addresses.
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int N          = DEF_N,
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int LOG2N      = DEF_ADDR_SIZE,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int BF_LATENCY = DEF_BF_LATENCY
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_select,
  output logic [ADDR_SIZE-1:0]     addr_read_0,
  output logic [ADDR_SIZE-1:0]     addr_read_1,
  output logic [ADDR_SIZE-1:0]     addr_write_0,
  output logic [ADDR_SIZE-1:0]     addr_write_1,
  output logic                     wr_en,
  output logic [ADDR_SIZE-2:0]     twiddle_addr,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     result_bank
);

  localparam int KW = ADDR_SIZE - 1;
  localparam int SW = $clog2(LOG2N);
  localparam int D  = RD_LAT + BF_LATENCY;
  localparam int CW = $clog2(D + 1);

  localparam logic [KW-1:0] K_LAST = KW'(N / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [CW-1:0] C_LAST = CW'(D - 1);

  fft_state_t    state, state_d;
  logic [KW-1:0] k, k_d;
  logic [SW-1:0] stg, stg_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          sel, sel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      k     <= '0;
      stg   <= '0;
      cnt   <= '0;
      sel   <= 1'b0;
    end else begin
      state <= state_d;
      k     <= k_d;
      stg   <= stg_d;
      cnt   <= cnt_d;
      sel   <= sel_d;
    end
  end

  always_comb begin
    state_d = state;
    k_d     = k;
    stg_d   = stg;
    cnt_d   = cnt;
    sel_d   = sel;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          stg_d   = '0;
          sel_d   = 1'b0;
        end
      end
      RUN: begin
        if (k == K_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          k_d = k + KW'(1);
        end
      end
      DRAIN: begin
        if (cnt == C_LAST) state_d = SWAP;
        else cnt_d = cnt + CW'(1);
      end
      SWAP: begin
        sel_d = ~sel;
        if (stg == S_LAST) begin
          state_d = FIN;
        end else begin
          stg_d   = stg + SW'(1);
          k_d     = '0;
          state_d = RUN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic                 run;
  logic [ADDR_SIZE-1:0] kk, span, pos, grp;
  logic [ADDR_SIZE-1:0] nat0, nat1, rd0, rd1;
  logic [KW-1:0]        tw;

  assign run = (state == RUN);

  always_comb begin
    kk   = {1'b0, k};
    span = ADDR_SIZE'(1) << stg;
    pos  = kk & (span - ADDR_SIZE'(1));
    grp  = kk >> stg;
    nat0 = ((grp << stg) << 1) | pos;
    nat1 = nat0 | span;
    tw   = KW'(pos << (LOG2N - 1 - int'(stg)));
`ifdef FFT_CTRL_BITREV_EN
    // Stage 0 gathers natural-order input; writes stay in place.
    if (stg == '0) begin
      rd0 = ADDR_SIZE'(bitrev(32'(nat0), ADDR_SIZE));
      rd1 = ADDR_SIZE'(bitrev(32'(nat1), ADDR_SIZE));
    end else begin
      rd0 = nat0;
      rd1 = nat1;
    end
`else
    rd0 = nat0;
    rd1 = nat1;
`endif
  end

  fft_addr_delay #(
    .W     (ADDR_SIZE),
    .DEPTH (D)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .src_valid (run),
    .src_a0    (nat0),
    .src_a1    (nat1),
    .wr_en     (wr_en),
    .wr_a0     (addr_write_0),
    .wr_a1     (addr_write_1)
  );

  assign addr_read_0  = run ? rd0 : '0;
  assign addr_read_1  = run ? rd1 : '0;
  assign twiddle_addr = run ? tw : '0;
  assign busy         = (state != IDLE);
  assign done         = (state == FIN);
  assign ram_select   = sel;
  assign result_bank  = sel;
  assign stage        = stg;

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Directed bench for fft_stage_ctrl at N=8 with a read/write vector table.
// Build with FFT_CTRL_BITREV_EN to exercise the stage-0 reversed reads.
module tb_fft_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       busy, done, ram_select, wr_en, result_bank;
  logic [2:0] addr_read_0, addr_read_1, addr_write_0, addr_write_1;
  logic [1:0] twiddle_addr;
  logic [1:0] stage;

  int nchk = 0;
  int nerr = 0;

  typedef struct packed {
    logic [2:0] r0;
    logic [2:0] r1;
    logic [1:0] tw;
    logic [2:0] w0;
    logic [2:0] w1;
  } vec_t;

  vec_t tbl [12];

  fft_stage_ctrl #(
    .N          (8),
    .ADDR_SIZE  (3),
    .LOG2N      (3),
    .RD_LAT     (1),
    .BF_LATENCY (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .ram_select   (ram_select),
    .addr_read_0  (addr_read_0),
    .addr_read_1  (addr_read_1),
    .addr_write_0 (addr_write_0),
    .addr_write_1 (addr_write_1),
    .wr_en        (wr_en),
    .twiddle_addr (twiddle_addr),
    .stage        (stage),
    .result_bank  (result_bank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_sel"}, 32'(ram_select), 0);
    chk({tag, "_stage"}, 32'(stage), 0);
    chk({tag, "_rd"}, 32'({addr_read_0, addr_read_1}), 0);
    chk({tag, "_wr"}, 32'({addr_write_0, addr_write_1}), 0);
    chk({tag, "_tw"}, 32'(twiddle_addr), 0);
  endtask

  // One full transform; caller is at a negedge with the DUT in IDLE.
  task automatic run_full(input bit hold);
    int   nwr;
    int   ntog;
    int   s;
    int   r;
    logic psel;
    vec_t v;
    nwr  = 0;
    ntog = 0;
    psel = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      s = (c - 1) / 8;
      r = (c - 1) % 8;
      chk("busy", 32'(busy), 32'(c <= 25));
      chk("done", 32'(done), 32'(c == 25));
      chk("sel", 32'(ram_select), 32'(s & 1));
      if (c <= 25) chk("stage", 32'(stage), (s > 2) ? 2 : s);
      if (s < 3 && r < 4) begin
        v = tbl[s*4+r];
        chk("rd_pair", 32'({addr_read_0, addr_read_1}), 32'({v.r0, v.r1}));
        chk("twiddle", 32'(twiddle_addr), 32'(v.tw));
      end
      if (s < 3 && r >= 3 && r <= 6) begin
        v = tbl[s*4+r-3];
        chk("wr_en", 32'(wr_en), 1);
        chk("wr_pair", 32'({addr_write_0, addr_write_1}), 32'({v.w0, v.w1}));
      end else begin
        chk("wr_en_idle", 32'(wr_en), 0);
      end
      if (c == 25) chk("result_bank", 32'(result_bank), 1);
      if (wr_en) nwr++;
      if (c <= 25 && ram_select != psel) ntog++;
      psel = ram_select;
      if (!hold || c == 26) start = 1'b0;
    end
    chk("wr_count", 32'(nwr), 12);
    chk("sel_toggles", 32'(ntog), 3);
    repeat (4) begin
      @(negedge clk);
      chk("stays_idle", 32'(busy), 0);
    end
  endtask

  initial begin
    tbl[0]  = '{3'd0, 3'd1, 2'd0, 3'd0, 3'd1};
    tbl[1]  = '{3'd2, 3'd3, 2'd0, 3'd2, 3'd3};
    tbl[2]  = '{3'd4, 3'd5, 2'd0, 3'd4, 3'd5};
    tbl[3]  = '{3'd6, 3'd7, 2'd0, 3'd6, 3'd7};
    tbl[4]  = '{3'd0, 3'd2, 2'd0, 3'd0, 3'd2};
    tbl[5]  = '{3'd1, 3'd3, 2'd2, 3'd1, 3'd3};
    tbl[6]  = '{3'd4, 3'd6, 2'd0, 3'd4, 3'd6};
    tbl[7]  = '{3'd5, 3'd7, 2'd2, 3'd5, 3'd7};
    tbl[8]  = '{3'd0, 3'd4, 2'd0, 3'd0, 3'd4};
    tbl[9]  = '{3'd1, 3'd5, 2'd1, 3'd1, 3'd5};
    tbl[10] = '{3'd2, 3'd6, 2'd2, 3'd2, 3'd6};
    tbl[11] = '{3'd3, 3'd7, 2'd3, 3'd3, 3'd7};
`ifdef FFT_CTRL_BITREV_EN
    tbl[0].r0 = 3'd0; tbl[0].r1 = 3'd4;
    tbl[1].r0 = 3'd2; tbl[1].r1 = 3'd6;
    tbl[2].r0 = 3'd1; tbl[2].r1 = 3'd5;
    tbl[3].r0 = 3'd3; tbl[3].r1 = 3'd7;
`endif

    rst   = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    run_full(1'b0);
    run_full(1'b1);
    run_full(1'b0);

    // Reset in the middle of stage 1 with writes still in flight.
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_sel", 32'(ram_select), 1);
    rst = 1'b1;
    @(negedge clk);
    chk_idle_outputs("midrst");
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("post_rst_wr_en", 32'(wr_en), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end

    run_full(1'b0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
- Sequencer for an in-place radix-2 DIT FFT built around the `ram_block` ping-pong buffer.
- Per stage, it issues N/2 butterfly read-address pairs and the matching twiddle index. It delays those addresses through the butterfly latency to form write addresses and write enables.
- After each stage it drains the pipeline and toggles `ram_select`, so the next stage reads what the previous stage wrote.
- Signals `done` and reports the bank holding the result.

Parameters:
- N, 1024, FFT length (power of two, ≥4)
- ADDR_SIZE, 10, log2(N); width of RAM addresses
- LOG2N, 10, number of stages (= ADDR_SIZE)
- RD_LAT, 1, RAM read latency in cycles
- BF_LATENCY, 4, butterfly datapath pipeline depth in cycles

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin transform; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse, transform complete
- ram_select  out  1  ping-pong select to ram_block
- addr_read_0  out  ADDR_SIZE  butterfly upper-leg read address
- addr_read_1  out  ADDR_SIZE  butterfly lower-leg read address
- addr_write_0  out  ADDR_SIZE  upper-leg write address
- addr_write_1  out  ADDR_SIZE  lower-leg write address
- wr_en  out  1  write strobe; drive all four ram_block wr_en inputs (ram_block gates by ram_select)
- twiddle_addr  out  ADDR_SIZE-1  twiddle ROM index, aligned with addr_read_*
- stage  out  $clog2(LOG2N)  current stage index
- result_bank  out  1  ram_select value whose read side holds the final result, valid with done

Behaviour:
- Reset state, applied on the next edge while rst=1: state=IDLE; busy, done, wr_en, ram_select, stage, k all 0; all addresses 0.
- FSM states: IDLE, RUN, DRAIN, SWAP, FIN.
- IDLE:
  - start=1 → RUN at the next edge, with stage=0 and k=0.
  - ram_select keeps its reset value of 0 at the start of a transform.
- RUN: one butterfly per cycle, k = 0..N/2-1.
  - span = 1<<stage; pos = k & (span-1); grp = k >> stage.
  - addr_read_0 = (grp << (stage+1)) | pos.
  - addr_read_1 = addr_read_0 + span.
  - twiddle_addr = pos << (LOG2N-1-stage).
  - k = N/2-1 → DRAIN.
- Write path:
  - A read pair issued at cycle t produces wr_en=1 at cycle t+RD_LAT+BF_LATENCY.
  - At that cycle, addr_write_* equal that pair's natural (in-place) addresses.
  - Implemented as a valid+address delay line of depth RD_LAT+BF_LATENCY.
  - wr_en=0 at all other times.
- DRAIN: waits RD_LAT+BF_LATENCY cycles until the last write has been strobed, then → SWAP.
- SWAP: one cycle. Toggles ram_select.
  - If stage = LOG2N-1 → FIN.
  - Otherwise stage+1, k=0, → RUN.
- FIN: done=1 for one cycle, result_bank = ram_select, busy=0 next cycle, → IDLE.
- Timing:
  - Cycles per stage = N/2 + RD_LAT + BF_LATENCY + 1.
  - Start accepted to done = LOG2N × that + 1.
- Boundary conditions:
  - start while not IDLE: ignored.
  - start in the same cycle as the FIN pulse: ignored; a new transform is accepted only from IDLE.
  - rst mid-transform: all outputs return to reset values on the next edge; the delay line is cleared so no stray wr_en is issued.
- Address arithmetic is ADDR_SIZE-bit unsigned; addr_read_1 never exceeds N-1 by construction.

Optional Feature:
- FFT_CTRL_BITREV_EN defined:
  - During stage 0 only, addr_read_0/1 are the ADDR_SIZE-bit bit-reversal of the natural addresses.
  - Write addresses stay natural, so natural-order input yields natural-order output.
- Not defined:
  - No reversal; input must be preloaded in bit-reversed order.
  - Read and write addresses are identical per pair.

Decomposition:
- Shared package fft_pkg holds:
  - FSM state enum: IDLE/RUN/DRAIN/SWAP/FIN.
  - Constants: default N, ADDR_SIZE, RD_LAT, BF_LATENCY.
  - bitrev function.
- One sub-module, fft_addr_delay: parameterised valid+2×address shift register that produces wr_en/addr_write_*.

Test Plan (N=8, LOG2N=3, ADDR_SIZE=3, RD_LAT=1, BF_LATENCY=2):
- Reset, then start pulse → read pairs per stage:
  - stage 0: (0,1)(2,3)(4,5)(6,7).
  - stage 1: (0,2)(1,3)(4,6)(5,7).
  - stage 2: (0,4)(1,5)(2,6)(3,7).
  - twiddle_addr: stage 0 all 0; stage 1 0,2,0,2; stage 2 0,1,2,3.
- Same run → each wr_en occurs exactly 3 cycles after its read pair, with identical addresses; exactly 12 wr_en cycles total; ram_select toggles 3 times; done arrives 25 cycles after start, with result_bank=1.
- start held high throughout the run → only one transform executes; a second start asserted after returning to IDLE runs a new transform, again starting from ram_select=0.
- rst asserted at cycle 10 of a run → next cycle: busy=0, wr_en=0, ram_select=0, and no wr_en until the next start.
- FFT_CTRL_BITREV_EN defined → stage 0 reads (0,4)(2,6)(1,5)(3,7) and writes (0,1)(2,3)(4,5)(6,7); stages 1–2 unchanged.
